// File: rtl/gps_ca_pkg.sv
// Shared definitions for the multi-channel GPS C/A generator: register map, LFSR taps, FSM states.
// The continuous/epoch feature is controlled by the macro GPS_CA_CONTINUOUS_EN.
package gps_ca_pkg;

    localparam int REG_CTRL    = 'h00;
    localparam int REG_STATUS  = 'h04;
    localparam int REG_CH_CFG  = 'h10;
    localparam int REG_CH_CODE = 'h40;
    localparam int REG_EPOCH   = 'h80;

    // Stage sN lives in bit N-1; masks select the feedback stages
    localparam logic [9:0] G1_FB_MASK = 10'h204;
    localparam logic [9:0] G2_FB_MASK = 10'h3A6;
    localparam logic [9:0] LFSR_SEED  = 10'h3FF;

    localparam int              TAP_W   = 4;
    localparam logic [TAP_W-1:0] TAP_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    function automatic logic [TAP_W-1:0] clamp_tap(input logic [TAP_W-1:0] v);
        return (v > TAP_MAX) ? TAP_MAX : v;
    endfunction

endpackage

// File: rtl/gps_ca_chan.sv
// One C/A code channel: G1/G2 LFSRs, programmable G2 tap pair and code capture register.
// With GPS_CA_CONTINUOUS_EN it also tracks the 1023-chip epoch and counts epochs.
module gps_ca_chan
    import gps_ca_pkg::*;
#(
    parameter int CODE_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [TAP_W-1:0]     tap1,
    input  logic [TAP_W-1:0]     tap2,
    output logic [CODE_BITS-1:0] code,
    output logic [15:0]          epoch,
    output logic                 wrap
);

    logic [9:0]  g1, g2, g1_nx, g2_nx;
    logic [15:0] g2_ext;
    logic        chip;

    assign g2_ext = {6'd0, g2};
    assign chip   = g1[9] ^ g2_ext[tap1] ^ g2_ext[tap2];
    assign g1_nx  = {g1[8:0], ^(g1 & G1_FB_MASK)};
    assign g2_nx  = {g2[8:0], ^(g2 & G2_FB_MASK)};

`ifdef GPS_CA_CONTINUOUS_EN
    logic [10:0] idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g1    <= LFSR_SEED;
            g2    <= LFSR_SEED;
            code  <= '0;
            idx   <= '0;
            epoch <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                g1    <= LFSR_SEED;
                g2    <= LFSR_SEED;
                code  <= '0;
                idx   <= '0;
                epoch <= '0;
            end else if (step) begin
                code <= (code << 1) | CODE_BITS'(chip);
                // Chip 1022 is the last of the epoch: restart both registers from the seed
                if (idx == 11'd1022) begin
                    g1   <= LFSR_SEED;
                    g2   <= LFSR_SEED;
                    idx  <= '0;
                    wrap <= 1'b1;
                    if (epoch != 16'hFFFF)
                        epoch <= epoch + 16'd1;
                end else begin
                    g1  <= g1_nx;
                    g2  <= g2_nx;
                    idx <= idx + 11'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g1   <= LFSR_SEED;
            g2   <= LFSR_SEED;
            code <= '0;
        end else if (load) begin
            g1   <= LFSR_SEED;
            g2   <= LFSR_SEED;
            code <= '0;
        end else if (step) begin
            code <= (code << 1) | CODE_BITS'(chip);
            g1   <= g1_nx;
            g2   <= g2_nx;
        end
    end

    assign epoch = '0;
    assign wrap  = 1'b0;
`endif

endmodule

// File: rtl/gps_ca_multichan.sv
// Multi-channel GPS C/A generator with register slave, run FSM and chip counter.
// Continuous mode, EPOCH registers and irq_o exist only with GPS_CA_CONTINUOUS_EN.
module gps_ca_multichan
    import gps_ca_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CODE_BITS = 32,
    parameter int ADDR_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              chip_en_i,
    input  logic              reg_wr_i,
    input  logic              reg_rd_i,
    input  logic [ADDR_W-1:0] reg_addr_i,
    input  logic [31:0]       reg_wdata_i,
    output logic [31:0]       reg_rdata_o,
    output logic              reg_rvalid_o,
    output logic              irq_o,
    output logic [1:0]        dbg_state_o
);

    localparam int CW = $clog2(CODE_BITS + 1);

    state_t               state, state_n;
    logic [CW-1:0]        chip_cnt;
    logic [NUM_CH-1:0]    mask, wrap;
    logic [7:0]           cfg   [NUM_CH];
    logic [CODE_BITS-1:0] code  [NUM_CH];
    logic [15:0]          epoch [NUM_CH];
    logic                 done, busy, ctrl_wr, start_wr, last_chip;
    logic                 load, run_step, set_done, cont_run, cont_req;
    logic [31:0]          rd_mux;

    assign busy        = (state != IDLE);
    assign ctrl_wr     = reg_wr_i && (reg_addr_i == ADDR_W'(REG_CTRL));
    assign start_wr    = ctrl_wr && reg_wdata_i[0];
    assign last_chip   = (chip_cnt == CW'(CODE_BITS - 1));
    assign dbg_state_o = state;

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        run_step = 1'b0;
        set_done = 1'b0;
        case (state)
            IDLE: if (start_wr) state_n = LOAD;
            LOAD: begin
                load    = 1'b1;
                state_n = RUN;
            end
            RUN: if (chip_en_i) begin
                run_step = 1'b1;
                if (cont_run) begin
                    if (!cont_req) state_n = IDLE;
                end else if (last_chip) begin
                    state_n  = IDLE;
                    set_done = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            chip_cnt <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_n;
            if (load)
                chip_cnt <= '0;
            else if (run_step && !cont_run)
                chip_cnt <= chip_cnt + CW'(1);
            if (state == IDLE && start_wr)
                done <= 1'b0;
            else if (set_done)
                done <= 1'b1;
        end
    end

    // Configuration is frozen while a run is in progress
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) cfg[ch] <= '0;
        end else if (reg_wr_i && !busy) begin
            if (ctrl_wr) mask <= reg_wdata_i[8 +: NUM_CH];
            for (int ch = 0; ch < NUM_CH; ch++)
                if (reg_addr_i == ADDR_W'(REG_CH_CFG + 4 * ch))
                    cfg[ch] <= {clamp_tap(reg_wdata_i[7:4]), clamp_tap(reg_wdata_i[3:0])};
        end
    end

`ifdef GPS_CA_CONTINUOUS_EN
    // cont_req is the live CTRL[1]; cont_run latches the mode chosen at start
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cont_req <= 1'b0;
            cont_run <= 1'b0;
        end else begin
            if (ctrl_wr) cont_req <= reg_wdata_i[1];
            if (state == IDLE) cont_run <= start_wr && reg_wdata_i[1];
        end
    end
`else
    assign cont_req = 1'b0;
    assign cont_run = 1'b0;
`endif

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        gps_ca_chan #(.CODE_BITS(CODE_BITS)) u_chan (
            .clk   (clk_i),
            .rst   (rst_i),
            .load  (load),
            .step  (run_step && mask[ch]),
            .tap1  (cfg[ch][3:0]),
            .tap2  (cfg[ch][7:4]),
            .code  (code[ch]),
            .epoch (epoch[ch]),
            .wrap  (wrap[ch])
        );
    end

    assign irq_o = |wrap;

    // Read strobe is sampled on a clock edge; data and a one-cycle rvalid follow on the next edge
    always_comb begin
        rd_mux = '0;
        if (reg_addr_i == ADDR_W'(REG_CTRL)) begin
            rd_mux[8 +: NUM_CH] = mask;
            rd_mux[1]           = cont_req;
        end
        if (reg_addr_i == ADDR_W'(REG_STATUS))
            rd_mux = {30'd0, done, busy};
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (reg_addr_i == ADDR_W'(REG_CH_CFG + 4 * ch))  rd_mux = {24'd0, cfg[ch]};
            if (reg_addr_i == ADDR_W'(REG_CH_CODE + 4 * ch)) rd_mux = 32'(code[ch]);
            if (reg_addr_i == ADDR_W'(REG_EPOCH + 4 * ch))   rd_mux = {16'd0, epoch[ch]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_rdata_o  <= '0;
            reg_rvalid_o <= 1'b0;
        end else begin
            reg_rvalid_o <= reg_rd_i;
            reg_rdata_o  <= reg_rd_i ? rd_mux : 32'd0;
        end
    end

endmodule
